// File: rtl/montgomery_pkg.sv
// Shared types and default sizing for the Montgomery reduce scheduler.
package montgomery_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } sched_state_t;

    localparam int DEF_REGISTER_SIZE = 32;
    localparam int DEF_NUM_BLOCKS    = 256;
    localparam int DEF_R             = 4096;

    // k and N are R bits wide, so they span R/REGISTER_SIZE blocks; so does the result.
    function automatic int const_blocks(input int r, input int reg_size);
        return r / reg_size;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up counter with enable and synchronous clear; clear wins over enable.
module wrap_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 128
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX - 1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == TOP) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/montgomery_reduce_scheduler.sv
// Shares one Montgomery reduce datapath between two requesters, one whole T
// operand at a time, and routes the reducer's result blocks back to the job owner.
module montgomery_reduce_scheduler
    import montgomery_pkg::*;
#(
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int NUM_BLOCKS    = DEF_NUM_BLOCKS,
    parameter int R             = DEF_R,
    parameter int CONST_BLOCKS  = const_blocks(R, REGISTER_SIZE),
    parameter int ADDR_W        = $clog2(CONST_BLOCKS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [1:0]               req_valid_in,
    input  logic [REGISTER_SIZE-1:0] req0_block_in,
    input  logic [REGISTER_SIZE-1:0] req1_block_in,
    output logic [1:0]               req_ready_out,
    output logic                     red_valid_out,
    output logic [REGISTER_SIZE-1:0] red_T_block_out,
    input  logic                     consumed_k_in,
    input  logic                     consumed_N_in,
    output logic [ADDR_W-1:0]        k_addr_out,
    output logic [ADDR_W-1:0]        n_addr_out,
    input  logic                     red_valid_in,
    input  logic [REGISTER_SIZE-1:0] red_block_in,
    output logic [1:0]               res_valid_out,
    output logic [REGISTER_SIZE-1:0] res_block_out,
    output logic                     res_last_out,
    output logic                     busy_out,
    output logic                     owner_out,
    output logic                     error_out
);

    localparam int CNT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [CNT_W-1:0]  IN_LAST  = CNT_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(CONST_BLOCKS - 1);

    sched_state_t      state, state_next;
    logic              owner, last_owner;
    logic [CNT_W-1:0]  in_cnt;
    logic [ADDR_W-1:0] out_cnt;
    logic              xfer, res_accept, res_final, grant_sel;

    // Handshake: a T block moves on any rising edge where req_valid_in[owner]
    // and req_ready_out[owner] are both high; a requester holds valid and data
    // stable until then. Ready depends only on state and owner, never on valid.
    assign req_ready_out = (state == STREAM) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign xfer          = (state == STREAM) && req_valid_in[owner];
    assign res_accept    = (state == DRAIN) && red_valid_in;
    assign res_final     = res_accept && (out_cnt == OUT_LAST);
    // On a tie the requester that did not own the previous job wins.
    assign grant_sel     = (&req_valid_in) ? ~last_owner : req_valid_in[1];
    assign busy_out      = (state != IDLE);
    assign owner_out     = owner;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid_in) state_next = STREAM;
            STREAM:  if (xfer && (in_cnt == IN_LAST)) state_next = DRAIN;
            DRAIN:   if (res_final) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            owner           <= 1'b0;
            last_owner      <= 1'b1;
            in_cnt          <= '0;
            out_cnt         <= '0;
            red_valid_out   <= 1'b0;
            red_T_block_out <= '0;
            res_valid_out   <= 2'b00;
            res_block_out   <= '0;
            res_last_out    <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            red_valid_out <= xfer;
            res_valid_out <= 2'b00;
            res_last_out  <= 1'b0;
            if (xfer) begin
                red_T_block_out <= owner ? req1_block_in : req0_block_in;
                in_cnt          <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
            end
            if ((state == IDLE) && (|req_valid_in)) begin
                owner <= grant_sel;
            end
            if (res_accept) begin
                res_valid_out <= owner ? 2'b10 : 2'b01;
                res_block_out <= red_block_in;
                res_last_out  <= res_final;
                out_cnt       <= res_final ? '0 : out_cnt + 1'b1;
            end
            if (res_final) begin
                last_owner <= owner;
            end
            // Stray result blocks and constant fetches with no job in flight are dropped.
            if ((red_valid_in && (state != DRAIN)) ||
                ((consumed_k_in || consumed_N_in) && (state == IDLE))) begin
                error_out <= 1'b1;
            end
        end
    end

    wrap_counter #(.WIDTH(ADDR_W), .MAX(CONST_BLOCKS)) u_k_addr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (consumed_k_in && (state != IDLE)),
        .clr    (res_final),
        .count  (k_addr_out)
    );

    wrap_counter #(.WIDTH(ADDR_W), .MAX(CONST_BLOCKS)) u_n_addr (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (consumed_N_in && (state != IDLE)),
        .clr    (res_final),
        .count  (n_addr_out)
    );

endmodule

// File: doc/montgomery_reduce_scheduler.md
Name: montgomery_reduce_scheduler

Overview:
- Schedules one montgomery_reduce datapath between two requesters, each submitting whole T operands of NUM_BLOCKS blocks, least-significant block first.
- Arbitration is round-robin at job granularity. Only one operand is in flight: the next grant waits until the current job's results have fully drained.
- Routes the reducer's result blocks back to the job owner.
- Drives the k and N constant-ROM block addresses from the reducer's consumed_k/consumed_N pulses.

Parameters:
- REGISTER_SIZE, 32, bits per block.
- NUM_BLOCKS, 256, blocks per T operand.
- R, 4096, Montgomery radix width in bits.
- CONST_BLOCKS, R/REGISTER_SIZE (128), blocks per k/N constant; also the result length in blocks.
- ADDR_W, $clog2(CONST_BLOCKS), width of the constant address.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- req_valid_in  in  2  per-requester block valid.
- req0_block_in  in  REGISTER_SIZE  requester 0 T block.
- req1_block_in  in  REGISTER_SIZE  requester 1 T block.
- req_ready_out  out  2  per-requester block accepted.
- red_valid_out  out  1  T block valid to reducer.
- red_T_block_out  out  REGISTER_SIZE  T block to reducer.
- consumed_k_in  in  1  reducer consumed a k block.
- consumed_N_in  in  1  reducer consumed an N block.
- k_addr_out  out  ADDR_W  k constant ROM address.
- n_addr_out  out  ADDR_W  N constant ROM address.
- red_valid_in  in  1  reducer result block valid.
- red_block_in  in  REGISTER_SIZE  reducer result block.
- res_valid_out  out  2  result block valid, one-hot to the owner.
- res_block_out  out  REGISTER_SIZE  result block.
- res_last_out  out  1  final result block of the job.
- busy_out  out  1  job in flight (state is not IDLE).
- owner_out  out  1  current or most recent owner.
- error_out  out  1  sticky protocol error.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state=IDLE; all counters 0; last_owner=1, so requester 0 wins the first tie.
  - All outputs 0.
- States: IDLE -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - req_ready_out=0.
  - Any req_valid_in high: register owner and go to STREAM next cycle. One cycle of arbitration latency.
  - Both requesters valid: grant the requester that is not last_owner.
  - Requesters hold valid while waiting; there is no timeout.
- STREAM:
  - req_ready_out[owner] = 1, combinationally from state and owner; the other bit is 0.
  - Transfer occurs on req_valid_in[owner] && ready.
  - red_valid_out/red_T_block_out are registered: one cycle after the transfer.
  - Valid gaps are allowed; in_cnt holds during a gap.
  - At in_cnt = NUM_BLOCKS-1 with a transfer, go to DRAIN. Ready drops the next cycle.
- DRAIN:
  - Each red_valid_in registers red_block_in onto res_block_out with res_valid_out[owner]=1. Latency 1 cycle.
  - out_cnt counts result blocks. On block CONST_BLOCKS-1, res_last_out=1 with it.
  - That cycle: return to IDLE, last_owner<=owner, zero all counters and both addresses.
  - A new grant is possible on the following cycle.
- Constant addresses:
  - Valid in STREAM and DRAIN.
  - k_addr_out increments on consumed_k_in; n_addr_out increments on consumed_N_in.
  - Each wraps CONST_BLOCKS-1 -> 0.
  - The two addresses are independent; a simultaneous pulse advances both.
- Error (error_out set and held until reset):
  - red_valid_in outside DRAIN: block dropped, nothing forwarded.
  - consumed_k_in or consumed_N_in in IDLE: address not changed.
- Simultaneous events: a last-result cycle coinciding with new req_valid_in still takes the IDLE arbitration cycle; there is no bypass.
- Reset mid-job: job discarded; no partial result is flagged last; requesters must resubmit from block 0.

Decomposition:
- Package montgomery_pkg:
  - sched_state_t enum (IDLE, STREAM, DRAIN).
  - Default REGISTER_SIZE/NUM_BLOCKS/R constants.
  - CONST_BLOCKS derivation.
- Sub-module wrap_counter: ADDR_W-bit counter with enable, synchronous clear, wrap at MAX-1, async active-low reset. Instantiated twice, for the k and N addresses.

Test Plan:
- Only req0 valid, NUM_BLOCKS=4, CONST_BLOCKS=2:
  - ready[0] high from cycle 2.
  - Four red_valid_out pulses carrying blocks 0x11..0x44 one cycle after each transfer.
  - Return red_valid_in ×2 -> res_valid_out=2'b01 twice, res_last_out on the second, busy_out falls.
- Both valid at reset release:
  - Owner 0 first, then owner 1, then owner 0 (alternation holds).
  - req_ready_out[1] stays 0 throughout job 0.
- req0 valid toggling 1,0,1,0 -> exactly NUM_BLOCKS transfers, in_cnt holds on gaps, the block order is preserved.
- consumed_k_in ×5 with CONST_BLOCKS=4 in DRAIN -> k_addr_out 1,2,3,0,1; n_addr_out unaffected.
- Simultaneous consumed_k_in and consumed_N_in -> both addresses advance by 1 in the same cycle.
- red_valid_in pulse in IDLE -> error_out=1 and held; no res_valid_out.
- Assert rst_in=0 mid-STREAM -> all outputs 0 asynchronously; after release, a new job completes normally.
